// File: rtl/pe_vector_mc.sv
// pe_vector_mc: Eyeriss PE row with ifmap, weight and psum scratchpads and a signed MAC.
// Define PE_PSUM_SAT_EN to saturate psum arithmetic instead of wrapping.
module pe_vector_mc #(
  parameter int DATA_BITWIDTH = 8,
  parameter int PSUM_BITWIDTH = 20,
  parameter int FIELD_W       = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [2:0]                 i_inst_data,
  input  logic [3*FIELD_W-1:0]       i_conv_info,
  input  logic                       i_inst_valid,
  output logic                       o_inst_ready,
  input  logic [DATA_BITWIDTH-1:0]   i_ifmap_data,
  input  logic                       i_ifmap_valid,
  output logic                       o_ifmap_ready,
  input  logic [DATA_BITWIDTH-1:0]   i_wght_data,
  input  logic                       i_wght_valid,
  output logic                       o_wght_ready,
  input  logic [PSUM_BITWIDTH-1:0]   i_psum_in_data,
  input  logic                       i_psum_in_valid,
  output logic                       o_psum_in_ready,
  output logic [PSUM_BITWIDTH-1:0]   o_psum_out_data,
  output logic                       o_psum_out_valid,
  input  logic                       i_psum_out_ready,
  output logic                       o_busy
);

  localparam int M           = (1 << FIELD_W) - 1;
  localparam int IFMAP_DEPTH = M * M;
  localparam int WGHT_DEPTH  = M * M * M;
  localparam int PSUM_DEPTH  = M;
  localparam int IFMAP_AW    = $clog2(IFMAP_DEPTH);
  localparam int WGHT_AW     = $clog2(WGHT_DEPTH);
  localparam int PSUM_AW     = $clog2(PSUM_DEPTH);
  localparam int CNT_W       = 3 * FIELD_W;
  localparam int IIDX_W      = 2 * FIELD_W;
  localparam int PROD_W      = 2 * DATA_BITWIDTH;
  localparam int SUM_W       = PSUM_BITWIDTH + 1;

  localparam logic [2:0] OP_SET        = 3'b001;
  localparam logic [2:0] OP_LOAD_IFMAP = 3'b010;
  localparam logic [2:0] OP_LOAD_WGHT  = 3'b011;
  localparam logic [2:0] OP_CONV       = 3'b100;
  localparam logic [2:0] OP_ACC        = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_LD_IFMAP,
    S_LD_WGHT,
    S_CONV,
    S_ACC
  } state_e;

  typedef logic signed [PSUM_BITWIDTH-1:0] psum_t;

  // Two's complement add of two psums; clamps on overflow when saturation is built in.
  function automatic psum_t psum_add(input psum_t a, input psum_t b);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
`ifdef PE_PSUM_SAT_EN
    if (sum[SUM_W-1] != sum[SUM_W-2]) begin
      return sum[SUM_W-1] ? {1'b1, {(PSUM_BITWIDTH-1){1'b0}}}
                          : {1'b0, {(PSUM_BITWIDTH-1){1'b1}}};
    end
`endif
    return sum[PSUM_BITWIDTH-1:0];
  endfunction

  state_e                    state_q, state_d;
  logic [2:0]                opcode_q, opcode_d;
  logic [FIELD_W-1:0]        p_q, p_d, q_q, q_d, s_q, s_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [FIELD_W-1:0]        pidx_q, pidx_d;
  logic [IIDX_W-1:0]         iidx_q, iidx_d;
  logic                      inst_ready_q, inst_ready_d;
  logic                      ifmap_ready_q, ifmap_ready_d;
  logic                      wght_ready_q, wght_ready_d;
  logic                      busy_q, busy_d;
  logic                      out_valid_q, out_valid_d;
  psum_t                     out_data_q, out_data_d;
  psum_t                     psum_q [PSUM_DEPTH];
  psum_t                     psum_d [PSUM_DEPTH];

  logic signed [DATA_BITWIDTH-1:0] ifmap_spad [IFMAP_DEPTH];
  logic signed [DATA_BITWIDTH-1:0] wght_spad  [WGHT_DEPTH];

  logic [CNT_W-1:0]                qs_total, pqs_total;
  logic                            fields_zero;
  logic                            ifmap_fire, wght_fire;
  logic                            psum_in_ready, psum_in_fire, out_accept;
  logic signed [DATA_BITWIDTH-1:0] ifmap_rd, wght_rd;
  logic signed [PROD_W-1:0]        prod;
  psum_t                           prod_ext, psum_rd;

  assign qs_total    = CNT_W'(q_q) * CNT_W'(s_q);
  assign pqs_total   = qs_total * CNT_W'(p_q);
  assign fields_zero = (p_q == '0) || (q_q == '0) || (s_q == '0);

  assign ifmap_fire    = ifmap_ready_q && i_ifmap_valid;
  assign wght_fire     = wght_ready_q && i_wght_valid;
  assign out_accept    = out_valid_q && i_psum_out_ready;
  // The pidx guard stops a further beat being taken while the last output waits.
  assign psum_in_ready = (state_q == S_ACC) && (pidx_q != p_q) &&
                         (!out_valid_q || i_psum_out_ready);
  assign psum_in_fire  = psum_in_ready && i_psum_in_valid;

  // During CONV cnt_q is the weight address, iidx_q = w / P and pidx_q = w mod P.
  assign ifmap_rd = ifmap_spad[iidx_q[IFMAP_AW-1:0]];
  assign wght_rd  = wght_spad[cnt_q[WGHT_AW-1:0]];
  assign prod     = ifmap_rd * wght_rd;
  assign prod_ext = PSUM_BITWIDTH'(prod);
  assign psum_rd  = psum_q[pidx_q[PSUM_AW-1:0]];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d     = state_q;
    opcode_d    = opcode_q;
    p_d         = p_q;
    q_d         = q_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    pidx_d      = pidx_q;
    iidx_d      = iidx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    psum_d      = psum_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_inst_valid && inst_ready_q) begin
          opcode_d = i_inst_data;
          state_d  = S_DEC;
          if (i_inst_data == OP_SET) begin
            p_d = i_conv_info[3*FIELD_W-1:2*FIELD_W];
            q_d = i_conv_info[2*FIELD_W-1:FIELD_W];
            s_d = i_conv_info[FIELD_W-1:0];
          end
        end
      end

      S_DEC: begin
        cnt_d   = '0;
        pidx_d  = '0;
        iidx_d  = '0;
        state_d = S_IDLE;
        if (!fields_zero) begin
          case (opcode_q)
            OP_LOAD_IFMAP: state_d = S_LD_IFMAP;
            OP_LOAD_WGHT:  state_d = S_LD_WGHT;
            OP_CONV:       state_d = S_CONV;
            OP_ACC:        state_d = S_ACC;
            default:       state_d = S_IDLE;
          endcase
        end
      end

      S_LD_IFMAP: begin
        if (ifmap_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == qs_total - CNT_W'(1)) state_d = S_IDLE;
        end
      end

      S_LD_WGHT: begin
        if (wght_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == pqs_total - CNT_W'(1)) state_d = S_IDLE;
        end
      end

      S_CONV: begin
        psum_d[pidx_q[PSUM_AW-1:0]] = psum_add(psum_rd, prod_ext);
        cnt_d = cnt_q + CNT_W'(1);
        if (pidx_q == p_q - FIELD_W'(1)) begin
          pidx_d = '0;
          iidx_d = iidx_q + IIDX_W'(1);
        end else begin
          pidx_d = pidx_q + FIELD_W'(1);
        end
        if (cnt_q == pqs_total - CNT_W'(1)) state_d = S_IDLE;
      end

      S_ACC: begin
        if (out_accept) out_valid_d = 1'b0;
        if (psum_in_fire) begin
          out_data_d                  = psum_add(psum_rd, psum_t'(i_psum_in_data));
          out_valid_d                 = 1'b1;
          psum_d[pidx_q[PSUM_AW-1:0]] = '0;
          pidx_d                      = pidx_q + FIELD_W'(1);
        end
        if (out_accept && (pidx_q == p_q)) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state, so they track state_q exactly.
  assign inst_ready_d  = (state_d == S_IDLE);
  assign ifmap_ready_d = (state_d == S_LD_IFMAP);
  assign wght_ready_d  = (state_d == S_LD_WGHT);
  assign busy_d        = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      p_q           <= '0;
      q_q           <= '0;
      s_q           <= '0;
      cnt_q         <= '0;
      pidx_q        <= '0;
      iidx_q        <= '0;
      inst_ready_q  <= 1'b0;
      ifmap_ready_q <= 1'b0;
      wght_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      psum_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      p_q           <= p_d;
      q_q           <= q_d;
      s_q           <= s_d;
      cnt_q         <= cnt_d;
      pidx_q        <= pidx_d;
      iidx_q        <= iidx_d;
      inst_ready_q  <= inst_ready_d;
      ifmap_ready_q <= ifmap_ready_d;
      wght_ready_q  <= wght_ready_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      psum_q        <= psum_d;
    end
  end

  // NOTE: ifmap/weight spads have no reset; they are always written by a load before being read.
  always_ff @(posedge i_clk) begin
    if (ifmap_fire) ifmap_spad[cnt_q[IFMAP_AW-1:0]] <= i_ifmap_data;
    if (wght_fire)  wght_spad[cnt_q[WGHT_AW-1:0]]   <= i_wght_data;
  end

  assign o_inst_ready     = inst_ready_q;
  assign o_ifmap_ready    = ifmap_ready_q;
  assign o_wght_ready     = wght_ready_q;
  assign o_psum_in_ready  = psum_in_ready;
  assign o_psum_out_data  = out_data_q;
  assign o_psum_out_valid = out_valid_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_pe_vector_mc.sv
// Self-checking bench for pe_vector_mc: randomized streams checked against a loop-level reference model.
module tb_pe_vector_mc;

  localparam int DW = 8;
  localparam int PW = 16;
  localparam int FW = 3;
  localparam longint PMAX = (longint'(1) <<< (PW - 1)) - 1;
  localparam longint PMIN = -PMAX - 1;
  localparam longint SPAN = PMAX * 2 + 2;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_LDW  = 3'b011;
  localparam logic [2:0] OP_CONV = 3'b100;
  localparam logic [2:0] OP_ACC  = 3'b101;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [2:0]      i_inst_data = '0;
  logic [3*FW-1:0] i_conv_info = '0;
  logic            i_inst_valid = 1'b0;
  logic            o_inst_ready;
  logic [DW-1:0]   i_ifmap_data = '0;
  logic            i_ifmap_valid = 1'b0;
  logic            o_ifmap_ready;
  logic [DW-1:0]   i_wght_data = '0;
  logic            i_wght_valid = 1'b0;
  logic            o_wght_ready;
  logic [PW-1:0]   i_psum_in_data = '0;
  logic            i_psum_in_valid = 1'b0;
  logic            o_psum_in_ready;
  logic [PW-1:0]   o_psum_out_data;
  logic            o_psum_out_valid;
  logic            i_psum_out_ready = 1'b0;
  logic            o_busy;

  pe_vector_mc #(.DATA_BITWIDTH(DW), .PSUM_BITWIDTH(PW), .FIELD_W(FW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_data(i_inst_data), .i_conv_info(i_conv_info),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_ifmap_data(i_ifmap_data), .i_ifmap_valid(i_ifmap_valid), .o_ifmap_ready(o_ifmap_ready),
    .i_wght_data(i_wght_data), .i_wght_valid(i_wght_valid), .o_wght_ready(o_wght_ready),
    .i_psum_in_data(i_psum_in_data), .i_psum_in_valid(i_psum_in_valid), .o_psum_in_ready(o_psum_in_ready),
    .o_psum_out_data(o_psum_out_data), .o_psum_out_valid(o_psum_out_valid),
    .i_psum_out_ready(i_psum_out_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     P = 0, Q = 0, S = 0;
  int     ifm [64];
  int     wt  [512];
  longint ps  [8];
  longint pin [8];

  // Psum arithmetic of the reference model: clamp or wrap to PW bits.
  function automatic longint fixp(input longint v);
    longint r;
`ifdef PE_PSUM_SAT_EN
    r = (v > PMAX) ? PMAX : ((v < PMIN) ? PMIN : v);
`else
    r = v % SPAN;
    if (r < 0) r += SPAN;
    if (r > PMAX) r -= SPAN;
`endif
    return r;
  endfunction

  task automatic apply_reset(input string name);
    i_inst_valid = 0; i_ifmap_valid = 0; i_wght_valid = 0;
    i_psum_in_valid = 0; i_psum_out_ready = 0;
    rst = 1'b1;
    #2;
    n_checks++;
    if ({o_inst_ready, o_ifmap_ready, o_wght_ready, o_psum_in_ready,
         o_psum_out_valid, o_psum_out_data, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs_in_reset got=%b want=0", name,
               {o_inst_ready, o_ifmap_ready, o_wght_ready, o_psum_in_ready,
                o_psum_out_valid, o_psum_out_data, o_busy});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_inst_ready, o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_ready_after_release got=%b want=10", name, {o_inst_ready, o_busy});
    end
    P = 0; Q = 0; S = 0;
    for (int k = 0; k < 8; k++) ps[k] = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3*FW-1:0] info);
    int g = 0;
    while (!o_inst_ready && g < 500) begin @(negedge clk); g++; end
    n_checks++;
    if (o_inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL inst_ready_wait got=%b want=1", o_inst_ready);
    end
    i_inst_valid = 1'b1; i_inst_data = op; i_conv_info = info;
    @(negedge clk);
    i_inst_valid = 1'b0; i_inst_data = 3'($urandom); i_conv_info = 9'($urandom);
  endtask

  // Issue an op that moves no data; check when o_inst_ready returns and that no stream opens.
  task automatic run_op(input logic [2:0] op, input logic [3*FW-1:0] info,
                        input int exp_lat, input string name);
    int   lat = 0;
    logic any_rdy = 1'b0;
    issue(op, info);
    i_ifmap_valid = 1; i_wght_valid = 1; i_psum_in_valid = 1; i_psum_out_ready = 1;
    #1;
    while (!o_inst_ready && lat < 2000) begin
      any_rdy |= o_ifmap_ready | o_wght_ready | o_psum_in_ready;
      @(negedge clk); #1; lat++;
    end
    i_ifmap_valid = 0; i_wght_valid = 0; i_psum_in_valid = 0; i_psum_out_ready = 0;
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    n_checks++;
    if (any_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_stream_ready got=%b want=0", name, any_rdy);
    end
    @(negedge clk);
  endtask

  task automatic set_fields(input int p, input int q, input int s);
    run_op(OP_SET, {3'(p), 3'(q), 3'(s)}, 1, "set");
    P = p; Q = q; S = s;
  endtask

  task automatic load_stream(input bit is_w);
    int   n = is_w ? P * Q * S : Q * S;
    int   k = 0, g = 0;
    logic v, rdy;
    issue(is_w ? OP_LDW : OP_LDI, '0);
    while (k < n && g < 3000) begin
      v = ($urandom % 4) != 0;
      if (is_w) begin i_wght_valid = v; i_wght_data = DW'(wt[k]); rdy = o_wght_ready; end
      else begin i_ifmap_valid = v; i_ifmap_data = DW'(ifm[k]); rdy = o_ifmap_ready; end
      @(negedge clk); g++;
      if (v && rdy) k++;
    end
    i_ifmap_valid = 0; i_wght_valid = 0;
    n_checks++;
    if (k != n || (is_w ? o_wght_ready : o_ifmap_ready) !== 1'b0 || o_inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_%s_end beats=%0d/%0d ready=%b inst_ready=%b want ready=0 inst_ready=1",
               is_w ? "wght" : "ifmap", k, n, is_w ? o_wght_ready : o_ifmap_ready, o_inst_ready);
    end
  endtask

  task automatic do_conv();
    run_op(OP_CONV, '0, P * Q * S + 1, "conv");
    for (int q = 0; q < Q; q++)
      for (int s = 0; s < S; s++)
        for (int p = 0; p < P; p++)
          ps[p] = fixp(ps[p] + longint'(ifm[q * S + s] * wt[(q * S + s) * P + p]));
  endtask

  // mode 0: random valid/ready; mode 1: hold out_ready low 5 cycles on the first output.
  task automatic do_acc(input int mode);
    longint exp_q [8];
    int     sent = 0, got = 0, g = 0, hold = 0, post = 0;
    logic   iv, orr, ov, ir;
    logic [PW-1:0] od, held;
    for (int p = 0; p < P; p++) begin exp_q[p] = fixp(ps[p] + pin[p]); ps[p] = 0; end
    issue(OP_ACC, '0);
    while (got < P && g < 2000) begin
      if (mode == 1) begin
        iv  = sent < P;
        orr = !(o_psum_out_valid && hold < 5);
      end else begin
        iv  = (sent < P) && ($urandom % 3 != 0);
        orr = $urandom % 3 != 0;
      end
      i_psum_in_valid = iv; i_psum_in_data = PW'(pin[sent]); i_psum_out_ready = orr;
      #1;
      ov = o_psum_out_valid; od = o_psum_out_data; ir = o_psum_in_ready;
      if (mode == 1 && !orr) begin
        if (hold == 0) held = od;
        n_checks++;
        if (ov !== 1'b1 || od !== held || ir !== 1'b0) begin
          n_fail++;
          $display("FAIL backpressure_hold[%0d] valid=%b data=%0d in_ready=%b want valid=1 data=%0d in_ready=0",
                   hold, ov, $signed(od), ir, $signed(held));
        end
        hold++;
      end else if (mode == 1 && hold == 5) begin
        post++;
      end
      if (ov && orr) begin
        n_checks++;
        if (od !== PW'(exp_q[got])) begin
          n_fail++;
          $display("FAIL acc_out[%0d] got=%0d want=%0d", got, $signed(od), exp_q[got]);
        end
        got++;
      end
      if (iv && ir) sent++;
      @(negedge clk); g++;
    end
    i_psum_in_valid = 0; i_psum_out_ready = 0;
    n_checks++;
    if (got != P || o_psum_out_valid !== 1'b0 || o_inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL acc_end outputs=%0d/%0d valid=%b inst_ready=%b want valid=0 inst_ready=1",
               got, P, o_psum_out_valid, o_inst_ready);
    end
    if (mode == 1) begin
      n_checks++;
      if (post != P) begin
        n_fail++;
        $display("FAIL backpressure_rate cycles=%0d want=%0d", post, P);
      end
    end
  endtask

  task automatic fill_pattern();
    for (int q = 0; q < Q; q++)
      for (int s = 0; s < S; s++) begin
        ifm[q * S + s] = s + 1;
        for (int p = 0; p < P; p++) wt[(q * S + s) * P + p] = s + 1;
      end
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_accumulate();
    set_fields(6, 4, 3);
    fill_pattern();
    load_stream(0);
    load_stream(1);
    do_conv();
    for (int p = 0; p < 8; p++) pin[p] = 10;
    do_acc(0);
  endtask

  task automatic test_multichannel();
    do_conv();
    do_conv();
    for (int p = 0; p < 8; p++) pin[p] = 0;
    do_acc(0);
    do_acc(0);
  endtask

  task automatic test_backpressure();
    do_conv();
    for (int p = 0; p < 8; p++) pin[p] = longint'($urandom_range(0, 2000)) - 1000;
    do_acc(1);
  endtask

  task automatic test_saturation();
    set_fields(1, 1, 1);
    ifm[0] = 127; wt[0] = 127;
    load_stream(0);
    load_stream(1);
    repeat (3) do_conv();
    pin[0] = 0;
    do_acc(0);
  endtask

  task automatic test_reset_mid_conv();
    set_fields(6, 4, 3);
    fill_pattern();
    load_stream(0);
    load_stream(1);
    issue(OP_CONV, '0);
    repeat (30) @(negedge clk);
    apply_reset("reset_mid_conv");
    set_fields(6, 4, 3);
    load_stream(0);
    load_stream(1);
    do_conv();
    for (int p = 0; p < 8; p++) pin[p] = 10;
    do_acc(0);
  endtask

  task automatic test_zero_field();
    set_fields(0, 4, 3);
    run_op(OP_LDI, '0, 1, "zero_load_ifmap");
    run_op(OP_LDW, '0, 1, "zero_load_wght");
    run_op(OP_CONV, '0, 1, "zero_conv");
    run_op(OP_ACC, '0, 1, "zero_acc");
    run_op(3'b111, {3'd6, 3'd4, 3'd3}, 1, "reserved_111");
    run_op(3'b110, {3'd6, 3'd4, 3'd3}, 1, "reserved_110");
    run_op(OP_NOP, {3'd6, 3'd4, 3'd3}, 1, "nop");
    // P stays 0 only if the reserved opcodes did not behave as SET.
    run_op(OP_CONV, '0, 1, "conv_after_reserved");
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      set_fields($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(1, 7));
      for (int k = 0; k < Q * S; k++) ifm[k] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < P * Q * S; k++) wt[k] = int'($urandom_range(0, 255)) - 128;
      load_stream(0);
      load_stream(1);
      repeat (1 + $urandom % 2) do_conv();
      for (int p = 0; p < 8; p++) pin[p] = longint'($urandom_range(0, 65535)) - 32768;
      do_acc(0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout time=%0t want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_accumulate();
    test_multichannel();
    test_backpressure();
    test_saturation();
    test_reset_mid_conv();
    test_zero_field();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_vector_mc.md
Name: pe_vector_mc

Overview:
- Parametrised successor PE row for the Eyeriss array: signed MAC engine with ifmap, weight and psum scratchpads.
- Psums persist across repeated CONV commands, so multiple input channels accumulate before a single ACC drain.
- Sits between top control (instruction port) and GLB (ifmap/wght/psum streams). All streams use valid/ready.

Parameters:
- DATA_BITWIDTH, 8, signed ifmap/weight width
- PSUM_BITWIDTH, 20, signed psum width; must be >= 2*DATA_BITWIDTH
- FIELD_W, 3, width of each P/Q/S field; max value M = 2^FIELD_W-1
- Derived: IFMAP_DEPTH = M*M, WGHT_DEPTH = M*M*M, PSUM_DEPTH = M

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_inst_data  in  3  opcode: 000 NOP, 001 SET, 010 LOAD_IFMAP, 011 LOAD_WGHT, 100 CONV, 101 ACC, 110/111 reserved (treated as NOP)
- i_conv_info  in  3*FIELD_W  {P,Q,S}, sampled on SET
- i_inst_valid / o_inst_ready  in/out  1  instruction handshake
- i_ifmap_data  in  DATA_BITWIDTH;  i_ifmap_valid  in  1;  o_ifmap_ready  out  1
- i_wght_data  in  DATA_BITWIDTH;  i_wght_valid  in  1;  o_wght_ready  out  1
- i_psum_in_data  in  PSUM_BITWIDTH;  i_psum_in_valid  in  1;  o_psum_in_ready  out  1
- o_psum_out_data  out  PSUM_BITWIDTH;  o_psum_out_valid  out  1;  i_psum_out_ready  in  1
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - All outputs are 0, FSM is IDLE, P/Q/S = 0, all counters are 0.
  - The psum spad is cleared. Ifmap and weight spads are not reset.
  - Reset mid-operation aborts immediately; a partial CONV leaves no trace because the psums are cleared.
- FSM states: IDLE, DEC, LD_IFMAP, LD_WGHT, CONV, ACC.
- o_inst_ready = (state == IDLE). On valid&ready the opcode is registered and the FSM goes to DEC, which always lasts exactly 1 cycle.
- DEC routing:
  - SET latches P/Q/S.
  - NOP and reserved opcodes return to IDLE.
  - Other opcodes go to their op state.
  - If any field is 0, LOAD/CONV/ACC return to IDLE with no transfers.
- LD_IFMAP:
  - o_ifmap_ready = 1. Each beat writes ifmap[cnt] and increments cnt.
  - After Q*S beats: ready drops the next cycle, FSM goes to IDLE.
- LD_WGHT:
  - Same as LD_IFMAP, P*Q*S beats into wght[cnt].
  - Load order is Q outer, S middle, P inner, so weight address is a plain counter.
- CONV:
  - P*Q*S cycles, one MAC per cycle, no stalls.
  - The weight address w runs 0..P*Q*S-1. Ifmap index i = w/P (advances every P cycles). Psum index p = w mod P.
  - Each cycle: psum[p] += sext(ifmap[i]*wght[w]). The product is a full 2*DATA_BITWIDTH signed value, sign-extended.
  - Returns to IDLE the cycle after the last MAC; o_inst_ready is high P*Q*S+1 cycles after DEC.
  - Psums are not cleared, so successive CONVs accumulate.
- ACC:
  - Runs for p = 0..P-1.
  - o_psum_in_ready = ACC && (!o_psum_out_valid || i_psum_out_ready).
  - On an input beat: the output register gets psum[p] + i_psum_in_data, o_psum_out_valid = 1, psum[p] is cleared to 0, p increments.
  - Output data stays stable while valid && !ready.
  - A simultaneous output accept and input beat sustains one beat per cycle.
  - Returns to IDLE after the P-th output is accepted; o_psum_out_valid is then 0.
- Arithmetic is signed two's complement. Without the optional feature, overflow wraps modulo 2^PSUM_BITWIDTH.
- Inputs on ifmap/wght/psum_in are ignored outside their states, because ready is 0.

Optional Feature:
- Macro: PE_PSUM_SAT_EN
- Defined: CONV accumulation and ACC addition saturate to [-2^(PSUM_BITWIDTH-1), 2^(PSUM_BITWIDTH-1)-1].
- Undefined: both wrap. Timing is identical either way.

Test Plan:
- Accumulate: SET P=6,Q=4,S=3; ifmap pattern s+1 (1,2,3 x4); weights s+1, each repeated 6 times; CONV; ACC with psum_in=10 x6 -> six outputs of 66. CONV busy for exactly 72 cycles.
- Multi-channel: as above but CONV twice, then ACC with psum_in=0 -> six outputs of 112. A following ACC with 0 -> six outputs of 0 (spad cleared).
- Backpressure: during ACC hold i_psum_out_ready=0 for 5 cycles -> o_psum_out_valid stays 1, data stable, o_psum_in_ready=0. Release -> remaining beats at 1 per cycle, totals correct.
- Saturation (DATA=8, PSUM=16, P=Q=S=1, ifmap=127, wght=127): CONV x3, ACC with 0 -> 32767 with PE_PSUM_SAT_EN; -17149 without.
- Reset mid-CONV at cycle 30 of 72 -> all outputs 0, o_inst_ready=1 after release. Re-SET, reload, CONV, ACC with 10 -> 66 (no residue).
- Zero field: SET P=0 -> LOAD_IFMAP/CONV/ACC each return o_inst_ready after DEC+1 cycle with no readies asserted. Opcode 111 -> treated as NOP.
